// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types, constants and helpers for the Simon round checker
package simon_pkg;

  localparam int MAX_ROUNDS = 32;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_WRONG   = 2'd1,
    FC_TIMEOUT = 2'd2,
    FC_MULTI   = 2'd3
  } fail_code_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    PASS,
    FAIL
  } chk_state_t;

  // Zero-length rounds still check one step; oversize rounds cap at the bus depth.
  function automatic logic [5:0] clamp_len(input logic [5:0] round_len);
    if (round_len == 6'd0) return 6'd1;
    if (round_len > 6'(MAX_ROUNDS)) return 6'(MAX_ROUNDS);
    return round_len;
  endfunction

  // Codes 4..7 carry bit 2 set and can never match any button.
  function automatic logic colour_match(input colour_t c, input logic [3:0] buttons);
    return !c[2] && (buttons == (4'b0001 << c[1:0]));
  endfunction

endpackage

// File: rtl/press_timer.sv
// rtl/press_timer.sv - per-press cycle counter flagging when the allowed wait has run out
module press_timer #(
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/round_checker.sv
// rtl/round_checker.sv - checks player presses against the displayed colour sequence
module round_checker
  import simon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic                    flash_clk,
  input  logic                    reset,
  input  logic                    check_round,
  input  logic [5:0]              round_len,
  input  logic [3*MAX_ROUNDS-1:0] segment,
  input  logic [3:0]              player_input,
  output logic                    busy,
  output logic [4:0]              step,
  output logic                    round_pass,
  output logic                    round_fail,
  output logic [1:0]              fail_code
);

  chk_state_t state;
  fail_code_t code_q;
  logic [5:0] len;
  logic [3:0] prev_input;
  logic       press;
  logic       multi;
  logic       expired;
  logic       last_step;
  colour_t    cur_colour;

  // A press is only the rising edge out of all-released, so a held button never counts.
  assign press      = (prev_input == 4'b0) && (player_input != 4'b0);
  assign multi      = $countones(player_input) > 1;
  assign cur_colour = segment[int'(step)*3 +: 3];
  assign last_step  = ({1'b0, step} == (len - 6'd1));
  assign fail_code  = code_q;

  press_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (flash_clk),
    .resetn  (reset),
    .clr     (state != WAIT_PRESS),
    .en      (state == WAIT_PRESS),
    .expired (expired)
  );

  always_ff @(posedge flash_clk) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      step       <= '0;
      round_pass <= 1'b0;
      round_fail <= 1'b0;
      code_q     <= FC_NONE;
      len        <= 6'd1;
      prev_input <= '0;
    end else begin
      prev_input <= player_input;
      round_pass <= 1'b0;
      round_fail <= 1'b0;
      case (state)
        IDLE: begin
          if (check_round) begin
            len    <= clamp_len(round_len);
            step   <= '0;
            code_q <= FC_NONE;
            busy   <= 1'b1;
            state  <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (press) begin
            if (multi) begin
              code_q     <= FC_MULTI;
              round_fail <= 1'b1;
              state      <= FAIL;
            end else if (colour_match(cur_colour, player_input)) begin
              state <= WAIT_RELEASE;
            end else begin
              code_q     <= FC_WRONG;
              round_fail <= 1'b1;
              state      <= FAIL;
            end
          end else if (expired) begin
            code_q     <= FC_TIMEOUT;
            round_fail <= 1'b1;
            state      <= FAIL;
          end
        end
        WAIT_RELEASE: begin
          if (player_input == 4'b0) begin
            if (last_step) begin
              round_pass <= 1'b1;
              state      <= PASS;
            end else begin
              step  <= step + 5'd1;
              state <= WAIT_PRESS;
            end
          end
        end
        PASS, FAIL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_checker.sv
// tb/tb_round_checker.sv - scoreboard bench for round_checker
module tb_round_checker;
  import simon_pkg::*;

  localparam int TO = 8;

  logic                    flash_clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    check_round = 1'b0;
  logic [5:0]              round_len = '0;
  logic [3*MAX_ROUNDS-1:0] segment = '0;
  logic [3:0]              player_input = '0;
  logic                    busy;
  logic [4:0]              step;
  logic                    round_pass;
  logic                    round_fail;
  logic [1:0]              fail_code;

  round_checker #(.TIMEOUT_CYCLES(TO)) dut (
    .flash_clk    (flash_clk),
    .reset        (reset),
    .check_round  (check_round),
    .round_len    (round_len),
    .segment      (segment),
    .player_input (player_input),
    .busy         (busy),
    .step         (step),
    .round_pass   (round_pass),
    .round_fail   (round_fail),
    .fail_code    (fail_code)
  );

  always #5 flash_clk = ~flash_clk;

  int cyc = 0;
  always @(posedge flash_clk) cyc <= cyc + 1;

  typedef struct {
    logic       pass;
    logic [1:0] code;
    logic [4:0] stp;
    int         at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic pass, input logic [1:0] code,
                              input logic [4:0] stp, input int at);
    exp_t e;
    e.pass = pass;
    e.code = code;
    e.stp  = stp;
    e.at   = at;
    sb.push_back(e);
  endtask

  always @(negedge flash_clk) begin
    exp_t e;
    if (round_pass || round_fail) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse pass=%0d fail=%0d cycle=%0d", round_pass, round_fail, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {round_pass, round_fail}, e.pass ? 2 : 1);
        check("pulse_fail_code", fail_code, e.code);
        check("pulse_step", step, e.stp);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge flash_clk);
      #1;
    end
  endtask

  task automatic set_seg(input int i, input logic [2:0] c);
    segment[3*i +: 3] = c;
  endtask

  task automatic start(input logic [5:0] len);
    round_len   = len;
    check_round = 1'b1;
    tick();
    check_round = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic press(input logic [3:0] b);
    player_input = b;
    tick(2);
  endtask

  task automatic release_btn();
    player_input = 4'b0;
    tick(2);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("reset_busy", busy, 0);
    check("reset_step", step, 0);
    check("reset_pass", round_pass, 0);
    check("reset_fail", round_fail, 0);
    check("reset_code", fail_code, 0);
    reset = 1'b1;
    tick(2);

    // 1: three-step round, all correct
    set_seg(0, 3'd2); set_seg(1, 3'd0); set_seg(2, 3'd3);
    start(6'd3);
    press(4'b0100); release_btn();
    press(4'b0001); release_btn();
    press(4'b1000);
    expect_pulse(1'b1, 2'd0, 5'd2, cyc + 1);
    player_input = 4'b0;
    tick(4);
    check("t1_busy_idle", busy, 0);
    check("t1_code", fail_code, 0);
    check("t1_step_held", step, 2);

    // 2: wrong colour
    set_seg(0, 3'd1);
    start(6'd1);
    expect_pulse(1'b0, 2'd1, 5'd0, cyc + 1);
    player_input = 4'b0100;
    tick();
    tick();
    check("t2_busy_after_pulse", busy, 0);
    release_btn();
    check("t2_code_held", fail_code, 1);

    // 3: timeout after TO cycles in WAIT_PRESS
    start(6'd1);
    expect_pulse(1'b0, 2'd2, 5'd0, cyc + TO);
    tick(TO + 2);
    check("t3_busy", busy, 0);
    check("t3_code", fail_code, 2);

    // 4a: multi-press
    set_seg(0, 3'd0);
    start(6'd1);
    expect_pulse(1'b0, 2'd3, 5'd0, cyc + 1);
    player_input = 4'b0011;
    tick();
    release_btn();
    check("t4a_code", fail_code, 3);

    // 4b: round_len 0 behaves as 1
    set_seg(0, 3'd1);
    start(6'd0);
    press(4'b0010);
    expect_pulse(1'b1, 2'd0, 5'd0, cyc + 1);
    release_btn();
    tick(2);
    check("t4b_code", fail_code, 0);

    // 4c: invalid code 5 never matches, even on its low bits
    set_seg(0, 3'd5);
    start(6'd1);
    expect_pulse(1'b0, 2'd1, 5'd0, cyc + 1);
    player_input = 4'b0010;
    tick();
    release_btn();
    tick(2);

    // 4d: round_len 40 caps at 32 steps
    for (int i = 0; i < MAX_ROUNDS; i++) set_seg(i, 3'(i % 4));
    start(6'd40);
    for (int i = 0; i < MAX_ROUNDS; i++) begin
      press(4'b0001 << (i % 4));
      if (i == MAX_ROUNDS - 1) expect_pulse(1'b1, 2'd0, 5'd31, cyc + 1);
      release_btn();
    end
    tick(2);
    check("t4d_busy", busy, 0);

    // 5: ignored restart while busy, then reset mid-round at step 2
    set_seg(0, 3'd2); set_seg(1, 3'd0); set_seg(2, 3'd3);
    start(6'd3);
    press(4'b0100); release_btn();
    press(4'b0001); release_btn();
    check_round = 1'b1;
    tick();
    check_round = 1'b0;
    check("t5_busy_ignored_start", busy, 1);
    check("t5_step_ignored_start", step, 2);
    reset = 1'b0;
    tick();
    check("t5_reset_busy", busy, 0);
    check("t5_reset_step", step, 0);
    check("t5_reset_code", fail_code, 0);
    reset = 1'b1;
    tick(TO + 4);
    check("t5_still_idle", busy, 0);

    // 6: button held across start is not a press
    set_seg(0, 3'd3);
    player_input = 4'b1000;
    tick(2);
    start(6'd1);
    tick(3);
    check("t6_held_no_step", busy, 1);
    check("t6_held_step", step, 0);
    player_input = 4'b0;
    tick();
    press(4'b1000);
    expect_pulse(1'b1, 2'd0, 5'd0, cyc + 1);
    release_btn();
    tick(2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses outstanding=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
